if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch-to-decode pipeline buffer: the next generation of the single-entry IF/ID instruction register. It holds `DEPTH` fetched entries, each an instruction word, its PC and PC+4, in a circular queue. Valid/ready handshakes run on both sides, and a synchronous flush discards all entries. It sits between the fetch unit and the decoder, so fetch can run ahead while decode stalls, and branches and redirects can squash wrong-path instructions in one cycle.

## Interface
- `n`, 32, width of instruction, PC and PC+4 fields.
- `DEPTH`, 2, number of entries; a power of two, ≥ 2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `flush`  input  1  synchronous squash of all entries.
- `in_valid`  input  1  fetch presents an entry.
- `in_ready`  output  1  queue can accept an entry.
- `instruction_next`  input  n  fetched instruction.
- `pc_next`  input  n  PC of fetched instruction.
- `pc_plus_four_next`  input  n  PC+4 of fetched instruction.
- `out_valid`  output  1  head entry is valid.
- `out_ready`  input  1  decode consumes the head entry.
- `instruction`  output  n  head instruction.
- `pc`  output  n  head PC.
- `pc_plus_four`  output  n  head PC+4.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage is `DEPTH` registered entries, plus write pointer `wr_ptr`, read pointer `rd_ptr` and occupancy `count`.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- `in_ready` = (count != DEPTH). It is combinational from `count` only, with no bypass. When the queue is full, a pop in the same cycle does not raise `in_ready`.
- `out_valid` = (count != 0).
- Push = `in_valid` && `in_ready`. A push writes all three fields to entry[wr_ptr] and then increments `wr_ptr`.
- Pop = `out_valid` && `out_ready`. A pop increments `rd_ptr`.
- Count update:
  - push only: `count` + 1.
  - pop only: `count` − 1.
  - push and pop together: `count` unchanged.
- Outputs `instruction`, `pc` and `pc_plus_four` are a combinational read of entry[rd_ptr]. They change only on clock edges, never directly from inputs.
- Flush: at the next edge, `wr_ptr`, `rd_ptr` and `count` go to 0.
  - Flush overrides any push or pop in the same cycle. The incoming entry is dropped and the head is not consumed.
  - Entry contents are not cleared by flush.
- Reset clears pointers, `count` and all entries to 0, immediately and independently of `clk`.
  - Reset mid-operation discards all entries.
  - The first push after reset is deasserted lands in entry 0.
- `in_valid` with `in_ready` low: the entry is not taken. Fetch must hold its data stable until accepted.
- `out_ready` while empty has no effect.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `count` = 0.
  - `instruction` = 0, or 0x00000013 with the macro (see Configuration).
  - `pc` = 0, `pc_plus_four` = 0.
- Latency is one cycle. An entry pushed at edge k appears on the outputs, with `out_valid` = 1, after edge k when the queue was empty before k.
- Throughput is one push and one pop per cycle when 0 < `count` < DEPTH.
- Flush asserted in cycle k: `out_valid` = 0 and `in_ready` = 1 after edge k.
- A push in cycle k+1 is accepted normally.

## Configuration
- Macro: `IF_ID_QUEUE_BUBBLE_NOP_EN`.
- Defined: while `out_valid` = 0, `instruction` is forced to 0x00000013 (RISC-V `addi x0,x0,0`), and `pc` and `pc_plus_four` are forced to 0. Decode then sees a clean bubble after empty, flush or reset.
- Undefined: outputs always show entry[rd_ptr], including stale contents when empty; consumers must qualify with `out_valid`.

## Test plan
- Reset: assert `reset` for 5 ns, off-edge → `count` = 0, `out_valid` = 0, `in_ready` = 1, `pc` = 0 before any clock edge.
- Single pass: push (55, 250, 1444) with `out_ready` = 0 → after the edge, `out_valid` = 1 and outputs read 55/250/1444; hold 3 cycles → values stable; raise `out_ready` → empty after the next edge.
- Fill and back-pressure (DEPTH = 2): push PCs 0x100 and 0x104 → `count` = 2, `in_ready` = 0.
  - Third push of 0x108 is ignored.
  - Two pops return 0x100 then 0x104, in order.
- Streaming and wrap: push and pop every cycle for 10 entries (PCs 0x200..0x224) → `count` stays 1, outputs appear in order, pointers wrap without loss.
- Flush priority: with 2 entries held, assert `flush`, `in_valid` and `out_ready` together → after the edge, `count` = 0; the pushed PC 0x300 never appears.
  - With the macro defined, `instruction` = 0x00000013 at that point.
- Reset mid-operation: with `count` = 1, pulse `reset` between edges → `out_valid` drops immediately; the next push is the only entry seen.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular fetch-to-decode buffer with flush.
// Optional macro IF_ID_QUEUE_BUBBLE_NOP_EN forces a NOP bubble while empty.
module if_id_queue #(
    parameter int n     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [n-1:0]               instruction_next,
    input  logic [n-1:0]               pc_next,
    input  logic [n-1:0]               pc_plus_four_next,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [n-1:0]               instruction,
    output logic [n-1:0]               pc,
    output logic [n-1:0]               pc_plus_four,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [n-1:0] NOP = n'(32'h0000_0013);

    logic [n-1:0]  ins_q [DEPTH];
    logic [n-1:0]  pc_q  [DEPTH];
    logic [n-1:0]  pc4_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign count     = cnt;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer and occupancy bookkeeping; flush squashes any push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; an accepted push writes all three fields at wr_ptr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ins_q[i] <= '0;
                pc_q[i]  <= '0;
                pc4_q[i] <= '0;
            end
        end else if (push && !flush) begin
            ins_q[wr_ptr] <= instruction_next;
            pc_q[wr_ptr]  <= pc_next;
            pc4_q[wr_ptr] <= pc_plus_four_next;
        end
    end

`ifdef IF_ID_QUEUE_BUBBLE_NOP_EN
    assign instruction  = out_valid ? ins_q[rd_ptr] : NOP;
    assign pc           = out_valid ? pc_q[rd_ptr]  : '0;
    assign pc_plus_four = out_valid ? pc4_q[rd_ptr] : '0;
`else
    assign instruction  = ins_q[rd_ptr];
    assign pc           = pc_q[rd_ptr];
    assign pc_plus_four = pc4_q[rd_ptr];
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed scenarios plus randomized traffic for if_id_queue.
// Expected behaviour comes from a queue-based model of the buffer.
module tb_if_id_queue;

    localparam int N     = 32;
    localparam int DEPTH = 2;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  instruction_next;
    logic [N-1:0]  pc_next;
    logic [N-1:0]  pc_plus_four_next;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  instruction;
    logic [N-1:0]  pc;
    logic [N-1:0]  pc_plus_four;
    logic [1:0]    count;

    logic [3*N-1:0] mq[$];
    int checks;
    int errors;

`ifdef IF_ID_QUEUE_BUBBLE_NOP_EN
    localparam logic [N-1:0] EMPTY_INS = 32'h0000_0013;
`else
    localparam logic [N-1:0] EMPTY_INS = 32'h0;
`endif

    if_id_queue #(.n(N), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instruction_next(instruction_next),
        .pc_next(pc_next),
        .pc_plus_four_next(pc_plus_four_next),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instruction(instruction),
        .pc(pc),
        .pc_plus_four(pc_plus_four),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, applying the queue rules to the model.
    task automatic tick();
        bit push;
        bit pop;
        logic [3*N-1:0] e;
        push = in_valid && (mq.size() != DEPTH);
        pop  = out_ready && (mq.size() != 0);
        e    = {instruction_next, pc_next, pc_plus_four_next};
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [N-1:0] i,
                         input logic [N-1:0] p, input bit r);
        in_valid          = v;
        instruction_next  = i;
        pc_next           = p;
        pc_plus_four_next = p + 32'd4;
        out_ready         = r;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if (count !== 2'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (pc !== 32'h0 || pc_plus_four !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %h/%h want 0/0", pc, pc_plus_four);
        end
        checks++;
        if (instruction !== EMPTY_INS) begin
            errors++;
            $display("FAIL reset_ins got %h want %h", instruction, EMPTY_INS);
        end
        #3 reset = 1'b0;
        mq.delete();
    endtask

    task automatic test_single();
        in_valid          = 1'b1;
        instruction_next  = 32'd55;
        pc_next           = 32'd250;
        pc_plus_four_next = 32'd1444;
        out_ready         = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || count !== 2'd1) begin
                errors++;
                $display("FAIL single_valid cyc %0d got v=%b c=%0d want 1/1",
                         k, out_valid, count);
            end
            checks++;
            if (instruction !== 32'd55 || pc !== 32'd250 ||
                pc_plus_four !== 32'd1444) begin
                errors++;
                $display("FAIL single_data cyc %0d got %0d/%0d/%0d want 55/250/1444",
                         k, instruction, pc, pc_plus_four);
            end
            if (k < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL single_pop got v=%b c=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        drive(1'b1, 32'hA, 32'h100, 1'b0);
        tick();
        drive(1'b1, 32'hB, 32'h104, 1'b0);
        tick();
        checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got c=%0d r=%b want 2/0", count, in_ready);
        end
        drive(1'b1, 32'hC, 32'h108, 1'b0);
        tick();
        checks++;
        if (count !== 2'd2 || pc !== 32'h100) begin
            errors++;
            $display("FAIL fill_ignore got c=%0d pc=%h want 2/100", count, pc);
        end
        drive(1'b1, 32'hC, 32'h108, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_nobypass got r=%b want 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (pc !== 32'h104 || count !== 2'd1 || instruction !== 32'hB) begin
            errors++;
            $display("FAIL fill_pop1 got pc=%h c=%0d want 104/1", pc, count);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_pop2 got c=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_stream();
        drive(1'b1, 32'h1000, 32'h200, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 32'h1000 + 32'(i), 32'h200 + 32'(4 * i), 1'b1);
            checks++;
            if (pc !== 32'h200 + 32'(4 * (i - 1)) || count !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d got pc=%h c=%0d want %h/1",
                         i, pc, count, 32'h200 + 32'(4 * (i - 1)));
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pc !== 32'h224 || count !== 2'd1) begin
            errors++;
            $display("FAIL stream_last got pc=%h c=%0d want 224/1", pc, count);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain got c=%0d want 0", count);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h21, 32'h280, 1'b0);
        tick();
        drive(1'b1, 32'h22, 32'h284, 1'b0);
        tick();
        drive(1'b1, 32'h33, 32'h300, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got c=%0d v=%b r=%b want 0/0/1",
                     count, out_valid, in_ready);
        end
`ifdef IF_ID_QUEUE_BUBBLE_NOP_EN
        checks++;
        if (instruction !== 32'h13 || pc !== 32'h0) begin
            errors++;
            $display("FAIL flush_bubble got %h/%h want 13/0", instruction, pc);
        end
`endif
        drive(1'b1, 32'h44, 32'h310, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (pc !== 32'h310 || count !== 2'd1 || instruction !== 32'h44) begin
            errors++;
            $display("FAIL flush_after got pc=%h c=%0d want 310/1", pc, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h55, 32'h400, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd1) begin
            errors++;
            $display("FAIL rmid_pre got c=%0d want 1", count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL rmid_drop got v=%b c=%0d want 0/0", out_valid, count);
        end
        #1 reset = 1'b0;
        mq.delete();
        drive(1'b1, 32'h66, 32'h500, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pc !== 32'h500 || count !== 2'd1 || instruction !== 32'h66) begin
            errors++;
            $display("FAIL rmid_next got pc=%h c=%0d want 500/1", pc, count);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_empty got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [3*N-1:0] h;
        for (int c = 0; c < 500; c++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 15) == 0);
            checks++;
            if (count !== 2'(mq.size()) ||
                in_ready !== (mq.size() != DEPTH) ||
                out_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rand_state cyc %0d got c=%0d r=%b v=%b want c=%0d",
                         c, count, in_ready, out_valid, mq.size());
            end
            if (mq.size() != 0) begin
                h = mq[0];
                checks++;
                if ({instruction, pc, pc_plus_four} !== h) begin
                    errors++;
                    $display("FAIL rand_head cyc %0d got %h/%h/%h want %h",
                             c, instruction, pc, pc_plus_four, h);
                end
            end
`ifdef IF_ID_QUEUE_BUBBLE_NOP_EN
            else begin
                checks++;
                if (instruction !== 32'h13 || pc !== 32'h0 ||
                    pc_plus_four !== 32'h0) begin
                    errors++;
                    $display("FAIL rand_bubble cyc %0d got %h/%h", c, instruction, pc);
                end
            end
`endif
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
